// File: rtl/mac_pkg.sv
// Shared constants, saturation helper and control bundle for the vector MAC.
package mac_pkg;

   localparam int DEF_IN_W    = 8;
   localparam int DEF_ACC_W   = 16;
   localparam int DEF_VEC_LEN = 4;
   localparam int DEF_SAT     = 1;

   // Per-stage valid bits travelling alongside the operand/product pipeline.
   typedef struct packed {
      logic v2;
      logic v1;
   } stage_vld_t;

   // Clamp a sign-extended (w+1)-bit sum into w signed bits.
   // Returns {overflow, clipped value sign-extended to 64 bits}.
   function automatic logic [64:0] sat_clip(input logic signed [63:0] s,
                                            input int                 w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (s > hi)      return {1'b1, hi};
      else if (s < lo) return {1'b1, lo};
      else             return {1'b0, s};
   endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulator + sign-extended product adder with
// optional saturation and an out-of-range flag.
module mac_sat_add
   import mac_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int P_W   = 2 * DEF_IN_W,
   parameter int SAT   = DEF_SAT
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [P_W-1:0]   p,
   output logic signed [ACC_W-1:0] sum,
   output logic                    ovf
);

   // One guard bit is enough: |p| fits in ACC_W bits, so the true sum fits in ACC_W+1.
   logic signed [ACC_W:0] sum_w;
   assign sum_w = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - P_W){p[P_W-1]}}, p};

   generate
      if (SAT != 0) begin : g_sat
         logic [64:0] clip_r;
         logic        clip_unused;
         assign clip_r      = sat_clip(64'(sum_w), ACC_W);
         assign clip_unused = &{1'b0, clip_r[63:ACC_W]};
         assign sum         = clip_r[ACC_W-1:0];
         assign ovf         = clip_r[64];
      end else begin : g_wrap
         // Guard bit disagreeing with the result sign means the low bits wrapped.
         assign sum = sum_w[ACC_W-1:0];
         assign ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
      end
   endgenerate

endmodule

// File: rtl/mac_vec_acc.sv
// Three-stage signed dot-product engine: register operands, register
// product, accumulate VEC_LEN products and emit one result per vector.
module mac_vec_acc
   import mac_pkg::*;
#(
   parameter int IN_W    = DEF_IN_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int VEC_LEN = DEF_VEC_LEN,
   parameter int SAT     = DEF_SAT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [IN_W-1:0]  a,
   input  logic signed [IN_W-1:0]  b,
   input  logic                    valid_in,
   input  logic                    clear,
   output logic signed [ACC_W-1:0] f,
   output logic                    valid_out,
   output logic                    ovf
);

   localparam int CNT_W = $clog2(VEC_LEN) + 1;
   localparam int P_W   = 2 * IN_W;

   stage_vld_t               vld;
   logic signed [IN_W-1:0]   a_r;
   logic signed [IN_W-1:0]   b_r;
   logic signed [P_W-1:0]    p;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  sum;
   logic                     add_ovf;
   logic                     ovf_acc;
   logic [CNT_W-1:0]         cnt;
   logic                     last;

   assign last = vld.v2 && (cnt == CNT_W'(VEC_LEN - 1));

   // Valid pipeline; clear kills in-flight elements but still admits this cycle's pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else begin
         vld.v1 <= valid_in;
         vld.v2 <= clear ? 1'b0 : vld.v1;
      end
   end

   // Stage 1: operand capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r <= '0;
         b_r <= '0;
      end else if (valid_in) begin
         a_r <= a;
         b_r <= b;
      end
   end

   // Stage 2: full-width signed product.
   always_ff @(posedge clk) begin
      if (reset)       p <= '0;
      else if (vld.v1) p <= a_r * b_r;
   end

   mac_sat_add #(
      .ACC_W (ACC_W),
      .P_W   (P_W),
      .SAT   (SAT)
   ) u_add (
      .acc (acc),
      .p   (p),
      .sum (sum),
      .ovf (add_ovf)
   );

   // Stage 3: accumulate; on the last element publish and restart from zero
   // so the next vector's element 0 never sees the old sum.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         ovf_acc   <= 1'b0;
         f         <= '0;
         ovf       <= 1'b0;
         valid_out <= 1'b0;
      end else if (clear) begin
         acc       <= '0;
         ovf_acc   <= 1'b0;
         valid_out <= 1'b0;
      end else if (last) begin
         f         <= sum;
         ovf       <= ovf_acc | add_ovf;
         valid_out <= 1'b1;
         acc       <= '0;
         ovf_acc   <= 1'b0;
      end else if (vld.v2) begin
         acc       <= sum;
         ovf_acc   <= ovf_acc | add_ovf;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
      end
   end

   // Element counter: position of the next stage-3 accumulation within the vector.
   always_ff @(posedge clk) begin
      if (reset || clear) cnt <= '0;
      else if (last)      cnt <= '0;
      else if (vld.v2)    cnt <= cnt + 1'b1;
   end

endmodule

// File: tb/tb_mac_vec_acc.sv
// Directed bench for mac_vec_acc: saturating and wrapping instances share stimulus.
module tb_mac_vec_acc;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [7:0]  a, b;
   logic               valid_in, clear;
   logic signed [15:0] f, f_w;
   logic               valid_out, valid_out_w, ovf, ovf_w;

   int n_chk = 0, n_fail = 0;
   int ecnt = 0;
   int np, pe_first, pf_first, po_first, pe, pf, po, consec;
   int npw, pfw, pow;
   logic prev_vo;

   always #5 clk = ~clk;

   mac_vec_acc #(.IN_W(8), .ACC_W(16), .VEC_LEN(4), .SAT(1)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear(clear),
      .f(f), .valid_out(valid_out), .ovf(ovf));

   mac_vec_acc #(.IN_W(8), .ACC_W(16), .VEC_LEN(4), .SAT(0)) dut_w (
      .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear(clear),
      .f(f_w), .valid_out(valid_out_w), .ovf(ovf_w));

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic mon_clr();
      np = 0; pe_first = -1; pf_first = 0; po_first = 0;
      pe = -1; pf = 0; po = 0; consec = 0;
      npw = 0; pfw = 0; pow = 0;
   endtask

   // Drive one cycle at the negedge, clock it in, then record pulses half a cycle later.
   task automatic tick(input logic v, input logic signed [7:0] ia,
                       input logic signed [7:0] ib, input logic clr);
      valid_in = v; a = ia; b = ib; clear = clr;
      @(posedge clk);
      ecnt++;
      @(negedge clk);
      if (valid_out) begin
         if (np == 0) begin
            pe_first = ecnt; pf_first = int'(f); po_first = int'(ovf);
         end
         np++; pe = ecnt; pf = int'(f); po = int'(ovf);
         if (prev_vo) consec++;
      end
      prev_vo = valid_out;
      if (valid_out_w) begin
         npw++; pfw = int'(f_w); pow = int'(ovf_w);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'sd0, 8'sd0, 1'b0);
   endtask

   initial begin
      int e1, e2;
      prev_vo = 1'b0;
      reset = 1'b1; valid_in = 1'b0; clear = 1'b0; a = '0; b = '0;
      mon_clr();

      // Reset held with live input; outputs stay zero during and after.
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 8'sd5, 8'sd5, 1'b0);
         check("rst_f", int'(f), 0);
         check("rst_vo", int'(valid_out), 0);
         check("rst_ovf", int'(ovf), 0);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 8'sd0, 8'sd0, 1'b0);
         check("post_rst_f", int'(f), 0);
         check("post_rst_vo", int'(valid_out), 0);
      end

      // Back-to-back vectors: 2*(1+2+3+4)=20, then -1*3*4=-12.
      mon_clr();
      tick(1'b1, 8'sd1, 8'sd2, 1'b0); tick(1'b1, 8'sd2, 8'sd2, 1'b0);
      tick(1'b1, 8'sd3, 8'sd2, 1'b0); tick(1'b1, 8'sd4, 8'sd2, 1'b0);
      e1 = ecnt;
      for (int i = 0; i < 4; i++) tick(1'b1, -8'sd1, 8'sd3, 1'b0);
      e2 = ecnt;
      idle(4);
      check("b2b_pulses", np, 2);
      check("b2b_f0", pf_first, 20);
      check("b2b_ovf0", po_first, 0);
      check("b2b_lat0", pe_first, e1 + 2);
      check("b2b_f1", pf, -12);
      check("b2b_ovf1", po, 0);
      check("b2b_lat1", pe, e2 + 2);
      check("b2b_consec", consec, 0);

      // Positive saturation vs wrap: 4*127*127 = 64516.
      mon_clr();
      for (int i = 0; i < 4; i++) tick(1'b1, 8'sd127, 8'sd127, 1'b0);
      idle(3);
      check("satp_pulses", np, 1);
      check("satp_f", pf, 32767);
      check("satp_ovf", po, 1);
      check("wrap_f", pfw, -1020);
      check("wrap_ovf", pow, 1);

      // Negative saturation: 4*(-128*127) = -65024.
      mon_clr();
      for (int i = 0; i < 4; i++) tick(1'b1, 8'sh80, 8'sd127, 1'b0);
      idle(3);
      check("satn_f", pf, -32768);
      check("satn_ovf", po, 1);

      // Gapped input: idle cycles between elements do not count.
      mon_clr();
      for (int i = 1; i <= 4; i++) begin
         tick(1'b1, 8'(i), 8'sd2, 1'b0);
         if (i == 4) e1 = ecnt;
         else idle(int'($urandom_range(0, 3)));
      end
      idle(4);
      check("gap_pulses", np, 1);
      check("gap_f", pf, 20);
      check("gap_ovf", po, 0);
      check("gap_lat", pe, e1 + 2);

      // Clear mid-vector with a pair in the same cycle: that pair becomes element 0.
      mon_clr();
      tick(1'b1, 8'sd10, 8'sd10, 1'b0); tick(1'b1, 8'sd10, 8'sd10, 1'b0);
      tick(1'b1, 8'sd1, 8'sd1, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b1, 8'sd1, 8'sd1, 1'b0);
      e1 = ecnt;
      idle(4);
      check("clr_pulses", np, 1);
      check("clr_f", pf, 4);
      check("clr_lat", pe, e1 + 2);

      // Clear with no valid after 3 elements: no pulse, f holds, next vector starts fresh.
      mon_clr();
      for (int i = 0; i < 3; i++) tick(1'b1, 8'sd1, 8'sd1, 1'b0);
      tick(1'b0, 8'sd0, 8'sd0, 1'b1);
      idle(4);
      check("clr2_pulses", np, 0);
      check("clr2_f_hold", int'(f), 4);
      for (int i = 0; i < 4; i++) tick(1'b1, 8'sd3, 8'sd3, 1'b0);
      idle(3);
      check("clr2_next_pulses", np, 1);
      check("clr2_next_f", pf, 36);

      // Reset mid-vector, then a full vector of 2*2.
      mon_clr();
      tick(1'b1, 8'sd5, 8'sd5, 1'b0); tick(1'b1, 8'sd5, 8'sd5, 1'b0);
      reset = 1'b1;
      tick(1'b1, 8'sd5, 8'sd5, 1'b0);
      reset = 1'b0;
      check("mrst_f", int'(f), 0);
      for (int i = 0; i < 4; i++) tick(1'b1, 8'sd2, 8'sd2, 1'b0);
      idle(4);
      check("mrst_pulses", np, 1);
      check("mrst_f16", pf, 16);
      check("mrst_ovf", po, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_vec_acc.md
# mac_vec_acc

Parametrised, pipelined signed multiply-accumulate engine. It is the successor of the single-stream accumulate-forever MAC. It sums fixed-length vectors of products (dot products), emits one result per VEC_LEN accepted input pairs, and restarts automatically with no bubble between vectors. It adds optional saturation, an overflow flag and a synchronous vector clear. It sits between an operand stream source and a result consumer in the datapath.

## Interface
- IN_W, 8: signed operand width.
- ACC_W, 16: signed accumulator/result width; must be >= 2*IN_W.
- VEC_LEN, 4: products per output vector; must be >= 1.
- SAT, 1: 1 = saturating accumulate; 0 = two's-complement wrap.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- a  in  IN_W  signed operand.
- b  in  IN_W  signed operand.
- valid_in  in  1  a/b valid this cycle; always accepted (no backpressure).
- clear  in  1  synchronous abort of current partial vector.
- f  out  ACC_W  signed vector result; holds between completions.
- valid_out  out  1  one-cycle pulse: f holds a new result.
- ovf  out  1  saturation/wrap occurred in the vector just output; qualified by valid_out, holds with f.

## Operation
- Stage 1 (input register): when valid_in=1, capture a and b, and set v1; otherwise v1=0.
- Stage 2 (product register): p = a*b at full 2*IN_W width, signed; v2 <= v1.
- Stage 3 (accumulate):
  - When v2=1, sum = acc + sign_extend(p, ACC_W), computed at ACC_W+1 bits.
  - Out-of-range result with SAT=1: clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Out-of-range result with SAT=0: keep the low ACC_W bits.
  - Either way, set sticky ovf_acc.
- Element counter cnt, $clog2(VEC_LEN)+1 bits, counts stage-3 accumulations.
- When v2=1 and cnt=VEC_LEN-1 (last element):
  - f <= sum; ovf <= ovf_acc | this-cycle overflow; valid_out <= 1.
  - acc <= 0; ovf_acc <= 0; cnt <= 0.
- When v2=1 and not last: acc <= sum; cnt++; valid_out <= 0.
- When v2=0: acc and cnt hold; valid_out <= 0.
- Idle cycles inside a vector are allowed; only valid elements count.
- VEC_LEN=1: every element produces a result f = saturated/wrapped a*b.
- clear=1:
  - Zero acc, cnt and ovf_acc; zero v1 and v2, killing in-flight elements.
  - valid_out <= 0. f and ovf hold.
  - If valid_in=1 in the same cycle, that pair is captured into stage 1 as element 0 of the new vector.
- reset=1: all registers zero (a/b regs, p, acc, cnt, v1, v2, f, ovf, valid_out), including mid-vector; reset has priority over clear and valid_in.

## Timing
- Reset values: f=0, valid_out=0, ovf=0.
- Latency: last element sampled at edge E, with valid_in=1, gives valid_out=1 and a new f from edge E+2 until edge E+3.
- Throughput: one pair per cycle sustained. Back-to-back vectors produce results exactly VEC_LEN cycles apart.
- valid_out is never high for two consecutive cycles unless VEC_LEN=1.
- Element 0 of the next vector may be in stage 3 in the same cycle as the previous vector's last element. It accumulates onto 0, never onto the old sum.

## Structure
- Package mac_pkg holds:
  - default parameter constants;
  - function sat_clip(ACC_W+1 → ACC_W, with overflow bit);
  - typedef for the stage valid/control bundle.
- One sub-module, mac_sat_add: combinational ACC_W + sign-extended product adder, with the SAT parameter and an overflow output. Instantiated in stage 3.
- Single always_ff per stage plus the control counter.

## Test plan
All scenarios use defaults unless noted (IN_W=8, ACC_W=16, VEC_LEN=4, SAT=1).
- Reset: hold reset 2 cycles with valid_in=1 and a=5, b=5 → f=0, valid_out=0, ovf=0 throughout and for 3 cycles after release.
- Back-to-back vectors: a=1,2,3,4 with b=2, then a=-1 ×4 with b=3, all consecutive → valid_out at E+2 with f=20, ovf=0; 4 cycles later f=-12; exactly two valid_out pulses.
- Saturation: a=b=127 ×4 → f=32767, ovf=1. a=-128, b=127 ×4 → f=-32768, ovf=1. With SAT=0, a=b=127 ×4 → f=-1020, ovf=1.
- Gapped input: a=1,2,3,4 with b=2, separated by 0–3 random idle cycles → single pulse with f=20, 2 edges after the 4th valid.
- Clear mid-vector: a=b=10 ×2, then clear with valid_in=1 and a=b=1, then 3 more a=b=1 → one result f=4. Clear asserted with no valid after 3 elements → no pulse, and f keeps its old value.
- Reset mid-vector: 2 elements, reset 1 cycle, then 4 elements of a=b=2 → f=16, no spurious pulse.
